// File: rtl/view_pkg.sv
// Shared constants and types for the game-view drawing path: screen geometry,
// colour key, arbiter FSM encoding and the draw-engine channel map.
package view_pkg;

  localparam int SCREEN_X_W = 9;
  localparam int SCREEN_Y_W = 8;
  localparam int COLOR_W    = 12;

  localparam logic [COLOR_W-1:0] TRANSPARENT_COLOR = 12'h000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int CH_BACKGROUND = 0;
  localparam int CH_GOLD       = 1;
  localparam int CH_STONE      = 2;
  localparam int CH_DIAMOND    = 3;
  localparam int CH_HOOK       = 4;
  localparam int CH_NUM        = 5;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational channel picker: lowest set request in fixed mode, or the first
// set request strictly after the pointer (wrapping) in round-robin mode.
module rr_pick
  import view_pkg::*;
#(
  parameter int NUM_CH = CH_NUM + 1,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  pointer,
  input  logic              mode,
  output logic [IDX_W-1:0]  winner,
  output logic              any_req
);

  int         w_idx;
  logic       w_found;

  // Scan NUM_CH candidates in priority order; the first hit wins.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = mode ? ((int'(pointer) + 1 + k) % NUM_CH) : k;
      if (!w_found && req[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        winner  = w_idx[IDX_W-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/draw_arbiter.sv
// Pixel-write arbiter: merges NUM_CH draw engines onto one registered VGA write
// port with a locked grant, per-channel colour-key suppression and a watchdog.
module draw_arbiter
  import view_pkg::*;
#(
  parameter int               NUM_CH      = CH_NUM + 1,
  parameter int               X_W         = SCREEN_X_W,
  parameter int               Y_W         = SCREEN_Y_W,
  parameter int               C_W         = COLOR_W,
  parameter logic [C_W-1:0]   TRANSPARENT = TRANSPARENT_COLOR,
  parameter int               RR_MODE     = 0,
  parameter int               TIMEOUT     = 131072
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH-1:0]     done,
  input  logic [NUM_CH*X_W-1:0] ch_x,
  input  logic [NUM_CH*Y_W-1:0] ch_y,
  input  logic [NUM_CH*C_W-1:0] ch_color,
  input  logic [NUM_CH-1:0]     ch_we,
  input  logic [NUM_CH-1:0]     transp_en,
  output logic [NUM_CH-1:0]     grant,
  output logic [X_W-1:0]        X_out,
  output logic [Y_W-1:0]        Y_out,
  output logic [C_W-1:0]        Color_out,
  output logic                  writeEn,
  output logic                  busy,
  output logic                  timeout_flag
);

  localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int               WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_CH - 1);
  localparam logic             MODE     = (RR_MODE != 0);
  localparam logic             WD_EN    = (TIMEOUT != 0);

  arb_state_t        r_state;
  logic [NUM_CH-1:0] r_grant;
  logic [IDX_W-1:0]  r_gidx;
  logic [IDX_W-1:0]  r_ptr;
  logic [WD_W-1:0]   r_wdog;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [C_W-1:0]    r_c;
  logic              r_we;
  logic              r_tflag;

  logic [IDX_W-1:0]  w_win;
  logic              w_any;
  logic [NUM_CH-1:0] w_onehot;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic [C_W-1:0]    w_c;
  logic              w_chwe;
  logic              w_transp;
  logic              w_done;
  logic              w_req;
  logic              w_key;
  logic              w_wd_hit;
  logic              w_release;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req     (req),
    .pointer (r_ptr),
    .mode    (MODE),
    .winner  (w_win),
    .any_req (w_any)
  );

  assign w_onehot = NUM_CH'(1) << w_win;

  // Only the granted channel's slice is visible; every other channel is ignored.
  always_comb begin
    w_x      = '0;
    w_y      = '0;
    w_c      = '0;
    w_chwe   = 1'b0;
    w_transp = 1'b0;
    w_done   = 1'b0;
    w_req    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_x      = ch_x[i*X_W +: X_W];
        w_y      = ch_y[i*Y_W +: Y_W];
        w_c      = ch_color[i*C_W +: C_W];
        w_chwe   = ch_we[i];
        w_transp = transp_en[i];
        w_done   = done[i];
        w_req    = req[i];
      end
    end
  end

  // Colour key is tested on the incoming pixel, not on the registered one.
  assign w_key     = w_transp & (w_c == TRANSPARENT);
  assign w_wd_hit  = WD_EN & (r_wdog == WD_LAST);
  assign w_release = w_done | ~w_req | w_wd_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= PTR_INIT;
      r_wdog  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= '0;
      r_we    <= 1'b0;
      r_tflag <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= LOCK;
            r_grant <= w_onehot;
            r_gidx  <= w_win;
            r_wdog  <= '0;
          end
        end
        LOCK: begin
          // The pixel of the releasing cycle is still written.
          r_x  <= w_x;
          r_y  <= w_y;
          r_c  <= w_c;
          r_we <= w_chwe & ~w_key;
          if (r_wdog != '1) begin
            r_wdog <= r_wdog + 1'b1;
          end
          if (w_release) begin
            r_state <= RELEASE;
            r_grant <= '0;
            r_ptr   <= r_gidx;
            if (w_wd_hit && !w_done && w_req) begin
              r_tflag <= 1'b1;
            end
          end
        end
        RELEASE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign X_out        = r_x;
  assign Y_out        = r_y;
  assign Color_out    = r_c;
  assign writeEn      = r_we;
  assign busy         = (r_state == LOCK);
  assign timeout_flag = r_tflag;

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: a fixed-priority and a round-robin instance share
// stimulus; written pixels are scored against a queue of expected writes.
module tb_draw_arbiter;

  localparam int N  = 6;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 12;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic [N-1:0]    req, done, ch_we, transp_en;
  logic [N*XW-1:0] ch_x;
  logic [N*YW-1:0] ch_y;
  logic [N*CW-1:0] ch_color;

  logic [N-1:0]    f_grant, r_grant;
  logic [XW-1:0]   f_x, r_x;
  logic [YW-1:0]   f_y, r_y;
  logic [CW-1:0]   f_c, r_c;
  logic            f_we, r_we, f_busy, r_busy, f_tf, r_tf;

  logic [N-1:0]    m_grant;
  logic [XW-1:0]   m_x;
  logic [YW-1:0]   m_y;
  logic [CW-1:0]   m_c;
  logic            m_we, m_busy, m_tf;

  bit sel = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
  } pix_t;

  pix_t sb[$];
  pix_t mon_e;

  draw_arbiter #(.NUM_CH(N), .X_W(XW), .Y_W(YW), .C_W(CW), .TRANSPARENT(12'h000),
                 .RR_MODE(0), .TIMEOUT(16)) u_fix (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .ch_x(ch_x), .ch_y(ch_y),
    .ch_color(ch_color), .ch_we(ch_we), .transp_en(transp_en), .grant(f_grant),
    .X_out(f_x), .Y_out(f_y), .Color_out(f_c), .writeEn(f_we), .busy(f_busy),
    .timeout_flag(f_tf));

  draw_arbiter #(.NUM_CH(N), .X_W(XW), .Y_W(YW), .C_W(CW), .TRANSPARENT(12'h000),
                 .RR_MODE(1), .TIMEOUT(16)) u_rr (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .ch_x(ch_x), .ch_y(ch_y),
    .ch_color(ch_color), .ch_we(ch_we), .transp_en(transp_en), .grant(r_grant),
    .X_out(r_x), .Y_out(r_y), .Color_out(r_c), .writeEn(r_we), .busy(r_busy),
    .timeout_flag(r_tf));

  assign m_grant = sel ? r_grant : f_grant;
  assign m_x     = sel ? r_x     : f_x;
  assign m_y     = sel ? r_y     : f_y;
  assign m_c     = sel ? r_c     : f_c;
  assign m_we    = sel ? r_we    : f_we;
  assign m_busy  = sel ? r_busy  : f_busy;
  assign m_tf    = sel ? r_tf    : f_tf;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", m_we, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_pixel", {m_x, m_y, m_c}, {mon_e.x, mon_e.y, mon_e.c});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; done = '0; ch_we = '0; transp_en = '0;
    ch_x = '0; ch_y = '0; ch_color = '0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic px(input int ch, input logic [8:0] x, input logic [7:0] y,
                    input logic [11:0] c, input logic we, input logic exp_w);
    ch_x[ch*XW +: XW]     = x;
    ch_y[ch*YW +: YW]     = y;
    ch_color[ch*CW +: CW] = c;
    ch_we[ch]             = we;
    if (exp_w) sb.push_back('{32'(cyc + 1), x, y, c});
    tick();
  endtask

  task automatic expect_grant(input logic [N-1:0] g);
    tick();
    chk("grant", m_grant, g);
    chk("busy_lock", m_busy, 1'b1);
  endtask

  task automatic rel(input int ch, input logic keep_req);
    ch_we[ch] = 1'b0;
    done[ch]  = 1'b1;
    tick();
    done[ch]  = 1'b0;
    req[ch]   = keep_req;
    chk("rel_grant", m_grant, '0);
    chk("rel_busy", m_busy, 1'b0);
    chk("rel_we", m_we, 1'b0);
    tick();
    chk("idle_grant", m_grant, '0);
  endtask

  initial begin
    int lk;
    req = '0; done = '0; ch_we = '0; transp_en = '0;
    ch_x = '0; ch_y = '0; ch_color = '0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_grant", m_grant, '0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_we", m_we, 1'b0);
    chk("rst_xyc", {m_x, m_y, m_c}, '0);
    chk("rst_tflag", m_tf, 1'b0);
    tick();
    resetn = 1'b1;
    tick();

    // single grant on ch1, three pixels then done
    sel = 1'b0;
    req = 6'b000010;
    expect_grant(6'b000010);
    px(1, 9'd10, 8'd20, 12'hFD0, 1'b1, 1'b1);
    px(1, 9'd11, 8'd20, 12'hFD0, 1'b1, 1'b1);
    px(1, 9'd12, 8'd20, 12'hFD0, 1'b1, 1'b1);
    rel(1, 1'b0);
    chk("x_hold", {m_x, m_y, m_c}, {9'd12, 8'd20, 12'hFD0});

    // colour key on ch2 (enabled) then ch0 (disabled)
    transp_en = 6'b000100;
    req = 6'b000100;
    expect_grant(6'b000100);
    px(2, 9'd30, 8'd40, 12'h000, 1'b1, 1'b0);
    chk("transp_key_we", m_we, 1'b0);
    px(2, 9'd31, 8'd40, 12'h888, 1'b1, 1'b1);
    chk("transp_pass_we", m_we, 1'b1);
    rel(2, 1'b0);
    req = 6'b000001;
    expect_grant(6'b000001);
    px(0, 9'd50, 8'd60, 12'h000, 1'b1, 1'b1);
    chk("bg_black_we", m_we, 1'b1);
    done[0] = 1'b1;
    px(0, 9'd51, 8'd60, 12'h888, 1'b1, 1'b1);
    chk("done_px_we", m_we, 1'b1);
    chk("done_px_busy", m_busy, 1'b0);
    done[0] = 1'b0; req[0] = 1'b0; ch_we[0] = 1'b0;
    tick();

    // fixed priority with ch2 re-requesting
    req = 6'b101100;
    expect_grant(6'b000100);
    rel(2, 1'b0);
    expect_grant(6'b001000);
    req[2] = 1'b1;
    rel(3, 1'b0);
    expect_grant(6'b000100);
    rel(2, 1'b0);
    expect_grant(6'b100000);
    rel(5, 1'b0);

    // round-robin, all channels requesting
    do_reset();
    sel = 1'b1;
    req = 6'b111111;
    for (int k = 0; k < 7; k++) begin
      expect_grant(6'b000001 << (k % N));
      repeat (3) tick();
      rel(k % N, 1'b1);
    end
    req = '0;
    tick();

    // watchdog release on a stuck ch4
    do_reset();
    sel = 1'b0;
    req = 6'b010000;
    expect_grant(6'b010000);
    lk = 1;
    repeat (15) begin
      tick();
      if (m_busy) lk++;
    end
    chk("wd_lock_len", lk, 16);
    chk("wd_flag_pre", m_tf, 1'b0);
    tick();
    chk("wd_rel_busy", m_busy, 1'b0);
    chk("wd_rel_grant", m_grant, '0);
    chk("wd_flag_set", m_tf, 1'b1);
    tick();
    expect_grant(6'b010000);
    repeat (3) tick();
    req[4] = 1'b0;
    tick();
    chk("abort_busy", m_busy, 1'b0);
    chk("wd_flag_sticky", m_tf, 1'b1);
    tick();

    // abort without watchdog
    do_reset();
    chk("wd_flag_rst", m_tf, 1'b0);
    req = 6'b010000;
    expect_grant(6'b010000);
    repeat (3) tick();
    req[4] = 1'b0;
    tick();
    chk("abort2_busy", m_busy, 1'b0);
    chk("abort2_grant", m_grant, '0);
    repeat (20) tick();
    chk("abort2_flag", m_tf, 1'b0);

    // asynchronous reset in the middle of a ch2 grant (round-robin)
    do_reset();
    sel = 1'b1;
    req = 6'b000110;
    expect_grant(6'b000010);
    rel(1, 1'b0);
    expect_grant(6'b000100);
    px(2, 9'd70, 8'd80, 12'hABC, 1'b1, 1'b1);
    #5;
    chk("pre_rst_we", m_we, 1'b1);
    resetn = 1'b0;
    req = 6'b001001;
    ch_we = '0;
    #1;
    chk("async_grant", m_grant, '0);
    chk("async_we", m_we, 1'b0);
    chk("async_busy", m_busy, 1'b0);
    tick();
    resetn = 1'b1;
    expect_grant(6'b000001);
    rel(0, 1'b0);
    expect_grant(6'b001000);
    rel(3, 1'b0);

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Parametrised pixel-write arbiter for the game view. It merges NUM_CH independent draw engines (background, gold, stone, diamond, hook, score digits, and others) onto the single VGA write port.
- One channel at a time holds a locked grant, from request until it signals done.
- Output is registered. Transparent-colour suppression is enabled per channel.
- Fixed-priority or round-robin selection, plus a watchdog that releases a stuck channel.

Parameters:
- NUM_CH, 6, number of draw channels.
- X_W, 9, pixel X width.
- Y_W, 8, pixel Y width.
- C_W, 12, colour width (RGB444).
- TRANSPARENT, 12'h000, colour key that is never written when transparency is enabled.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 131072, maximum grant length in cycles before forced release; 0 disables the watchdog.

Ports:
- clk, in, 1, system clock.
- resetn, in, 1, reset. Asynchronous, active-low.
- req, in, NUM_CH, per-channel draw request; level, held until done.
- done, in, NUM_CH, per-channel one-cycle done pulse.
- ch_x, in, NUM_CH*X_W, packed channel X; channel i occupies bits [i*X_W +: X_W].
- ch_y, in, NUM_CH*Y_W, packed channel Y.
- ch_color, in, NUM_CH*C_W, packed channel colour.
- ch_we, in, NUM_CH, per-channel pixel write strobe.
- transp_en, in, NUM_CH, per-channel transparency enable (0 for background).
- grant, out, NUM_CH, one-hot grant to the active channel.
- X_out, out, X_W, registered pixel X.
- Y_out, out, Y_W, registered pixel Y.
- Color_out, out, C_W, registered pixel colour.
- writeEn, out, 1, registered write strobe.
- busy, out, 1, high while a grant is held.
- timeout_flag, out, 1, sticky; set on watchdog release.

Behaviour:
- Reset (async, resetn=0): FSM to IDLE; grant=0, writeEn=0, X_out=0, Y_out=0, Color_out=0, busy=0, timeout_flag=0; RR pointer = NUM_CH-1 so that channel 0 is first in order; watchdog counter=0.
- FSM states: IDLE, LOCK, RELEASE.
- IDLE:
  - If req != 0, select the winner w. Fixed mode: lowest set index. RR mode: first set index strictly after the pointer, wrapping modulo NUM_CH.
  - Next cycle: grant=onehot(w), busy=1, state LOCK, watchdog=0.
  - If req == 0, stay in IDLE.
- LOCK, each cycle with granted index g:
  - X_out, Y_out and Color_out are loaded from channel g's slice.
  - writeEn <= ch_we[g] & ~(transp_en[g] & (ch_color[g]==TRANSPARENT)).
  - The transparency test uses the incoming colour of the same cycle, never the previous Color_out.
  - Latency from channel pixel to outputs is exactly 1 cycle.
  - Inputs of non-granted channels are ignored entirely.
- Release conditions, evaluated in LOCK:
  - done[g]=1, or req[g]=0 (abort), or watchdog == TIMEOUT-1 when TIMEOUT != 0.
  - On release: next state RELEASE, grant <= 0, RR pointer <= g.
  - On watchdog release only, timeout_flag <= 1.
  - A pixel presented in the same cycle as done[g] is still written, registered normally.
- RELEASE: one mandatory gap cycle with writeEn=0 and busy=0; outputs hold their X/Y/Color values; then go to IDLE. The minimum gap between grants is therefore 2 cycles (RELEASE + IDLE select).
- Outside LOCK, writeEn=0 and X_out/Y_out/Color_out hold their last values.
- done pulses from non-granted channels are ignored; they are not remembered.
- Watchdog: increments every LOCK cycle, saturates, and clears on entry to LOCK.
- timeout_flag clears only on reset.
- Simultaneous requests:
  - Fixed mode: a higher index can starve; this is accepted, and the top-level FSM sequences requests.
  - RR mode: every continuously requesting channel is granted within NUM_CH grants.
- Reset asserted mid-grant: everything returns to reset values immediately; a channel still requesting re-arbitrates after reset is released.

Decomposition:
- Shared package view_pkg holds:
  - the constants SCREEN_X_W=9, SCREEN_Y_W=8, COLOR_W=12 and TRANSPARENT_COLOR=12'h000;
  - the enum arb_state_t {IDLE, LOCK, RELEASE};
  - the channel index constants CH_BACKGROUND=0, CH_GOLD=1, CH_STONE=2, CH_DIAMOND=3, CH_HOOK=4, CH_NUM=5.
- One sub-module, rr_pick: a purely combinational priority picker. Inputs: req, pointer, mode. Outputs: winner index and any_req.
- The FSM, watchdog and output registers live in draw_arbiter.

Test Plan:
- Single grant: RR_MODE=0; req=6'b000010; ch1 drives 3 pixels (x=10,11,12, y=20, color=12'hFD0, we=1) and then done. Required: grant=000010; writeEn high for exactly 3 cycles, each 1 cycle after its input; then grant=0 and busy=0 for 1 RELEASE cycle.
- Transparency: ch2 with transp_en=1 drives color=12'h000 and then 12'h888, we=1. Required: writeEn is 0 then 1. The same stimulus on ch0 with transp_en=0 gives writeEn=1 for both.
- Fixed priority: req=6'b101100 held. Required: grant order ch2, ch3, ch5, with ch2 winning each time it re-requests.
- Round-robin: RR_MODE=1; req=6'b111111 held; each channel issues done after 4 cycles. Required: grant order 0,1,2,3,4,5,0, with a gap of ≥2 cycles between grants.
- Watchdog and abort:
  - TIMEOUT=16; ch4 is granted and never issues done. Required: release after 16 LOCK cycles and timeout_flag=1, which stays set until reset.
  - Separately, dropping req[4] mid-grant releases without setting timeout_flag.
- Async reset: resetn pulled low mid-LOCK, between clock edges. Required: grant, writeEn and busy go to 0 without waiting for an edge. After release, a pending req[3] is granted, and the RR order restarts from ch0.
